memory_access: RTL and testbench



---
 rtl/mips_pkg.sv | 16 +
 rtl/data_memory.sv | 29 ++
 rtl/memory_access.sv | 152 +++++++++++++++
 tb/tb_memory_access.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, load/store width codes and MEM halt FSM states.
package mips_pkg;

  localparam int NB_DATA_DEFAULT = 32;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory with per-byte write enables, one async read port and one async debug port.
// Writes commit on the rising edge; reads see the pre-write contents in the same cycle.
module data_memory
  import mips_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic [3:0]         we_i,
  input  logic [NB_ADDR-1:0] addr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  output logic [NB_DATA-1:0] rdata_o,
  input  logic [NB_ADDR-1:0] dbg_addr_i,
  output logic [NB_DATA-1:0] dbg_data_o
);

  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o    = mem_q[addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: byte/half/word load-store, 1-cycle MEM/WB register, halt FSM; i_stall freezes MEM/WB and blocks writes.
// Optional MEM_ALIGN_CHECK_EN adds o_misaligned and suppresses misaligned accesses.
module memory_access
  import mips_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic               i_mem2reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_halted
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic               o_misaligned
`endif
);

  state_e             state_q, state_d;
  logic               halted;
  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic               is_byte, is_half, is_word, misaligned;
  logic [3:0]         be, we;
  logic [NB_DATA-1:0] wdata, rd_word, dbg_word, load_ext, read_data_d;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic               reg_write_d;
  logic               unused_upper_addr;

  logic               mem2reg_q, reg_write_q, misaligned_q;
  logic [4:0]         write_reg_q;
  logic [NB_DATA-1:0] alu_result_q, read_data_q, debug_data_q;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_idx          = i_result[NB_ADDR+1:2];
  assign lane              = i_result[1:0];
  assign unused_upper_addr = ^i_result[NB_DATA-1:NB_ADDR+2];

  assign is_byte = (i_width == WIDTH_BYTE);
  assign is_half = (i_width == WIDTH_HALF);
  assign is_word = i_width[1];
  assign halted  = (state_q == ST_HALTED);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (i_memRead || i_memWrite) &&
                      ((is_half && lane[0]) || (is_word && (lane != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be    = 4'b1111;
    wdata = i_data4Mem;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wdata = {(NB_DATA/8){i_data4Mem[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {(NB_DATA/16){i_data4Mem[15:0]}};
    end
  end

  // Reset gates the enables so a store caught by reset is dropped.
  assign we = (i_memWrite && !i_stall && !halted && !misaligned && !i_rst) ? be : 4'b0000;

  data_memory #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_dmem (
    .clk        (clk),
    .we_i       (we),
    .addr_i     (word_idx),
    .wdata_i    (wdata),
    .rdata_o    (rd_word),
    .dbg_addr_i (i_debug_addr),
    .dbg_data_o (dbg_word)
  );

  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = rd_word;
    if (is_byte)      load_ext = {{(NB_DATA-8){i_sign_flag & rd_byte[7]}}, rd_byte};
    else if (is_half) load_ext = {{(NB_DATA-16){i_sign_flag & rd_half[15]}}, rd_half};
  end

  assign read_data_d = (i_memRead && !misaligned) ? load_ext : '0;
  assign reg_write_d = i_regWrite && !(misaligned && i_memRead);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_halt) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      mem2reg_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      misaligned_q <= 1'b0;
      write_reg_q  <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      debug_data_q <= '0;
    end else begin
      state_q      <= state_d;
      debug_data_q <= dbg_word;
      if (halted) begin
        reg_write_q <= 1'b0;
      end else if (!i_stall) begin
        mem2reg_q    <= i_mem2reg;
        reg_write_q  <= reg_write_d;
        misaligned_q <= misaligned;
        write_reg_q  <= i_write_reg;
        alu_result_q <= i_result;
        read_data_q  <= read_data_d;
      end
    end
  end

  assign o_mem2reg    = mem2reg_q;
  assign o_regWrite   = reg_write_q;
  assign o_write_reg  = write_reg_q;
  assign o_alu_result = alu_result_q;
  assign o_read_data  = read_data_q;
  assign o_debug_data = debug_data_q;
  assign o_halted     = halted;
`ifdef MEM_ALIGN_CHECK_EN
  assign o_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: driver pushes hand-computed MEM/WB expectations, monitor pops one per edge.
module tb_memory_access;
  import mips_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;

  localparam logic [6:0] MR = 7'd1, MA = 7'd2, MW = 7'd4, MH = 7'd8, MD = 7'd16, MX = 7'd32, MM = 7'd64;

  logic               clk = 1'b0;
  logic               i_rst, i_stall, i_halt;
  logic [NB_DATA-1:0] i_result, i_data4Mem;
  logic               i_mem2reg, i_memRead, i_memWrite, i_regWrite, i_sign_flag;
  logic [1:0]         i_width;
  logic [4:0]         i_write_reg;
  logic [NB_ADDR-1:0] i_debug_addr;
  logic               o_mem2reg, o_regWrite, o_halted;
  logic [4:0]         o_write_reg;
  logic [NB_DATA-1:0] o_alu_result, o_read_data, o_debug_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic               o_misaligned;
`endif

  memory_access #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_stall      (i_stall),
    .i_halt       (i_halt),
    .i_result     (i_result),
    .i_data4Mem   (i_data4Mem),
    .i_mem2reg    (i_mem2reg),
    .i_memRead    (i_memRead),
    .i_memWrite   (i_memWrite),
    .i_regWrite   (i_regWrite),
    .i_width      (i_width),
    .i_sign_flag  (i_sign_flag),
    .i_write_reg  (i_write_reg),
    .i_debug_addr (i_debug_addr),
    .o_mem2reg    (o_mem2reg),
    .o_regWrite   (o_regWrite),
    .o_write_reg  (o_write_reg),
    .o_alu_result (o_alu_result),
    .o_read_data  (o_read_data),
    .o_debug_data (o_debug_data),
    .o_halted     (o_halted)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .o_misaligned (o_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [6:0]  m;
    logic [31:0] rd, alu, dbg;
    logic        rw, hl, mis;
    logic [5:0]  wr6;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the expectation describes outputs after the next rising edge.
  task automatic drive(input int id, input logic rst, input logic rd, input logic wr,
                       input logic [1:0] w, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] data, input logic stall, input logic halt,
                       input logic [7:0] dbga, input logic [6:0] m, input logic [31:0] e_rd,
                       input logic [31:0] e_alu, input logic e_rw, input logic e_hl,
                       input logic [31:0] e_dbg, input logic e_mis);
    exp_t e;
    i_rst        = rst;
    i_memRead    = rd;
    i_memWrite   = wr;
    i_mem2reg    = rd;
    i_regWrite   = rd;
    i_width      = w;
    i_sign_flag  = sgn;
    i_result     = addr;
    i_data4Mem   = data;
    i_stall      = stall;
    i_halt       = halt;
    i_debug_addr = dbga;
    i_write_reg  = id[4:0];
    e.id  = id;  e.m = m;  e.rd = e_rd;  e.alu = e_alu;  e.dbg = e_dbg;
    e.rw  = e_rw; e.hl = e_hl; e.mis = e_mis;
    e.wr6 = rst ? 6'd0 : {rd, id[4:0]};
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.m[0]) chk(e.id, "read_data",  o_read_data,  e.rd);
        if (e.m[1]) chk(e.id, "alu_result", o_alu_result, e.alu);
        if (e.m[2]) chk(e.id, "regWrite",   {31'd0, o_regWrite}, {31'd0, e.rw});
        if (e.m[3]) chk(e.id, "halted",     {31'd0, o_halted},   {31'd0, e.hl});
        if (e.m[4]) chk(e.id, "debug_data", o_debug_data, e.dbg);
        if (e.m[5]) chk(e.id, "mem2reg_wreg", {26'd0, o_mem2reg, o_write_reg}, {26'd0, e.wr6});
`ifdef MEM_ALIGN_CHECK_EN
        if (e.m[6]) chk(e.id, "misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
`endif
      end
    end
  end

  initial begin : driver
    //    id rst rd wr width       sg addr        data          st hl dbg mask               e_rd          e_alu     rw hl e_dbg         mis
    drive(1,  1, 0, 1, WIDTH_WORD, 0, 32'h10,    32'h77,        0, 0, 0, MR|MA|MW|MH|MX,   32'h0,        32'h0,    0, 0, 32'h0,        0);
    drive(2,  0, 0, 1, WIDTH_WORD, 0, 32'h10,    32'hDEADBEEF,  0, 0, 0, MR|MA|MW|MH,      32'h0,        32'h10,   0, 0, 32'h0,        0);
    drive(3,  0, 1, 0, WIDTH_WORD, 0, 32'h10,    32'h0,         0, 0, 0, MR|MA|MW|MX,      32'hDEADBEEF, 32'h10,   1, 0, 32'h0,        0);
    drive(4,  0, 0, 1, WIDTH_BYTE, 0, 32'h13,    32'hFFFFFF80,  0, 0, 0, MR|MA,            32'h0,        32'h13,   0, 0, 32'h0,        0);
    drive(5,  0, 1, 0, WIDTH_BYTE, 1, 32'h13,    32'h0,         0, 0, 0, MR,               32'hFFFFFF80, 32'h0,    0, 0, 32'h0,        0);
    drive(6,  0, 1, 0, WIDTH_BYTE, 0, 32'h13,    32'h0,         0, 0, 0, MR,               32'h00000080, 32'h0,    0, 0, 32'h0,        0);
    drive(7,  0, 1, 0, WIDTH_WORD, 0, 32'h10,    32'h0,         0, 0, 4, MR|MD,            32'h80ADBEEF, 32'h0,    0, 0, 32'h80ADBEEF, 0);
    drive(8,  0, 0, 1, WIDTH_HALF, 0, 32'h22,    32'hABCD1234,  0, 0, 0, MR|MA,            32'h0,        32'h22,   0, 0, 32'h0,        0);
    drive(9,  0, 1, 0, WIDTH_HALF, 1, 32'h22,    32'h0,         0, 0, 0, MR,               32'h00001234, 32'h0,    0, 0, 32'h0,        0);
    drive(10, 0, 1, 0, WIDTH_BYTE, 0, 32'h23,    32'h0,         0, 0, 0, MR,               32'h00000012, 32'h0,    0, 0, 32'h0,        0);
    drive(11, 0, 1, 1, WIDTH_WORD, 0, 32'h10,    32'h01020304,  0, 0, 0, MR|MX,            32'h80ADBEEF, 32'h0,    0, 0, 32'h0,        0);
    drive(12, 0, 1, 0, 2'b10,      0, 32'h410,   32'h0,         0, 0, 0, MR|MA,            32'h01020304, 32'h410,  0, 0, 32'h0,        0);
    drive(13, 0, 0, 1, WIDTH_WORD, 0, 32'h40,    32'h11111111,  0, 0, 0, MA,               32'h0,        32'h40,   0, 0, 32'h0,        0);
    drive(14, 0, 1, 0, WIDTH_WORD, 0, 32'h40,    32'h0,         0, 0, 0, MR|MA|MW,         32'h11111111, 32'h40,   1, 0, 32'h0,        0);
    drive(15, 0, 0, 1, WIDTH_WORD, 0, 32'h40,    32'h5,         1, 0, 0, MR|MA|MW,         32'h11111111, 32'h40,   1, 0, 32'h0,        0);
    drive(16, 0, 1, 0, WIDTH_WORD, 0, 32'h40,    32'h0,         0, 0, 0, MR|MA|MW,         32'h11111111, 32'h40,   1, 0, 32'h0,        0);
    drive(17, 0, 0, 1, WIDTH_HALF, 0, 32'h45,    32'h00008001,  0, 0, 0, MR|MA,            32'h0,        32'h45,   0, 0, 32'h0,        0);
    drive(18, 0, 1, 0, WIDTH_HALF, 1, 32'h44,    32'h0,         0, 0, 0, MR,               32'hFFFF8001, 32'h0,    0, 0, 32'h0,        0);
    drive(19, 0, 0, 1, WIDTH_WORD, 0, 32'h08,    32'hA5A5A5A5,  0, 1, 0, MA|MH,            32'h0,        32'h08,   0, 0, 32'h0,        0);
    drive(20, 0, 1, 0, WIDTH_WORD, 0, 32'h08,    32'h0,         0, 0, 0, MR|MA|MW|MH,      32'hA5A5A5A5, 32'h08,   1, 1, 32'h0,        0);
    drive(21, 0, 1, 1, WIDTH_WORD, 0, 32'h08,    32'h12345678,  0, 0, 0, MR|MA|MW|MH,      32'hA5A5A5A5, 32'h08,   0, 1, 32'h0,        0);
    drive(22, 0, 1, 0, WIDTH_WORD, 0, 32'h0,     32'h0,         0, 0, 2, MR|MA|MW|MH|MD,   32'hA5A5A5A5, 32'h08,   0, 1, 32'hA5A5A5A5, 0);
    drive(23, 1, 0, 1, WIDTH_WORD, 0, 32'h08,    32'h77,        0, 0, 2, MR|MA|MW|MH|MX,   32'h0,        32'h0,    0, 0, 32'h0,        0);
    drive(24, 0, 1, 0, WIDTH_WORD, 0, 32'h08,    32'h0,         0, 0, 2, MR|MA|MW|MH|MD,   32'hA5A5A5A5, 32'h08,   1, 0, 32'hA5A5A5A5, 0);
`ifdef MEM_ALIGN_CHECK_EN
    drive(25, 0, 1, 0, WIDTH_WORD, 0, 32'h11,    32'h0,         0, 0, 0, MR|MA|MW|MM,      32'h0,        32'h11,   0, 0, 32'h0,        1);
    drive(26, 0, 0, 1, WIDTH_WORD, 0, 32'h11,    32'hFFFFFFFF,  0, 0, 0, MA|MM,            32'h0,        32'h11,   0, 0, 32'h0,        1);
    drive(27, 0, 1, 0, WIDTH_WORD, 0, 32'h10,    32'h0,         0, 0, 0, MR|MW|MM,         32'h01020304, 32'h0,    1, 0, 32'h0,        0);
    drive(28, 0, 1, 0, WIDTH_HALF, 0, 32'h13,    32'h0,         0, 0, 0, MR|MW|MM,         32'h0,        32'h0,    0, 0, 32'h0,        1);
`endif
    i_memRead  = 1'b0;
    i_memWrite = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
